// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word memory responder with fixed wait states and error reporting
module mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic [1:0]  busy_state
);

   localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic          cap_wr;
   logic [31:0]   cap_addr;
   logic [31:0]   cap_wdata;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          access;
   logic          acc_err;
   logic [AW-1:0] idx;

   // The access edge is the last WAIT cycle; everything below keys off it.
   assign access  = (state == S_WAIT) && (cnt == 4'd0);
   assign acc_err = (cap_addr[1:0] != 2'b00) || ({1'b0, cap_addr} >= BYTE_LIMIT);
   assign idx     = cap_addr[AW+1:2];

   assign busy_state = state;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         cap_wr    <= 1'b0;
         cap_addr  <= 32'd0;
         cap_wdata <= 32'd0;
         ready     <= 1'b1;
         ack       <= 1'b0;
         err       <= 1'b0;
         rdata     <= 32'd0;
      end else begin
         ready <= 1'b0;
         ack   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  cap_wr    <= wr;
                  cap_addr  <= addr;
                  cap_wdata <= wdata;
                  cnt       <= 4'(WAIT_STATES);
                  state     <= S_WAIT;
               end else begin
                  ready <= 1'b1;
               end
            end
            S_WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state <= S_RESP;
                  ack   <= 1'b1;
                  err   <= acc_err;
                  if (acc_err) begin
                     rdata <= 32'd0;
                  end else if (!cap_wr) begin
                     rdata <= mem[idx];
                  end
               end
            end
            S_RESP: begin
               state <= S_IDLE;
               ready <= 1'b1;
               err   <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               ready <= 1'b1;
               err   <= 1'b0;
            end
         endcase
      end
   end

   // Array has no reset so contents survive a reset pulse.
   always_ff @(posedge clock) begin
      if (access && cap_wr && !acc_err) begin
         mem[idx] <= cap_wdata;
      end
   end

endmodule
